// File: rtl/condflow_pkg.sv
// Shared definitions for the condflow token blocks: control-index width
// helper, slot state encoding and the channel-count ceiling.
package condflow_pkg;

    // Largest number of input channels a selector is built for.
    localparam int MAX_K = 16;

    // Width of an index able to address 'value' items; never below one bit
    // so a single-entry selector still has a real port.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Occupancy of a one-entry token slot. The slot's data lives next to
    // this flag inside token_slot, whose width is a parameter.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/token_slot.sv
// One-entry token buffer: accepts a token when empty, holds it until the
// owner clears it. Ready is simply "not full". Asynchronous active-low reset.
module token_slot
    import condflow_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r,
    input  logic [W-1:0] d,
    input  logic         clr,
    output logic         a,
    output logic         full,
    output logic [W-1:0] q
);

    slot_state_e state;

    // Fill on a handshake, empty on clear. Clear only arrives while the slot
    // is full (and therefore not ready), so the two never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SLOT_EMPTY;
            q     <= '0;
        end else if (clr) begin
            state <= SLOT_EMPTY;
        end else if (r && a) begin
            state <= SLOT_FULL;
            q     <= d;
        end
    end

    assign full = (state == SLOT_FULL);
    assign a    = !full;

endmodule

// File: rtl/swap_sink_n.sv
// K-way swap-with-sink: collects one token from every input plus one control
// token, forwards the selected input and drains the rest.
// Optional feature: define SWAP_SINK_N_DROP_CNT_EN to add the saturating
// drop_cnt port counting discarded tokens.
module swap_sink_n
    import condflow_pkg::*;
#(
    parameter  int N   = 1,
    parameter  int K   = 2,
    parameter  int DCW = 16,
    localparam int CW  = safe_clog2(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K-1:0]   r_i,
    output logic [K-1:0]   a_i,
    input  logic [K*N-1:0] d_i,
    input  logic           ctl_r,
    output logic           actl_i,
    input  logic [CW-1:0]  ctl_d,
    output logic           r_o,
    input  logic           a_o,
    output logic [N-1:0]   d_o,
    output logic           err_o
`ifdef SWAP_SINK_N_DROP_CNT_EN
    ,
    output logic [DCW-1:0] drop_cnt
`endif
);

    localparam logic [CW:0] K_LIM = (CW+1)'(K);

    logic [K-1:0]  in_full;
    logic [N-1:0]  in_q [K];
    logic          ctl_full;
    logic [CW-1:0] ctl_q;

    logic          fire;
    logic          in_range;
    logic [N-1:0]  sel_data;

    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          err_q;

    // One slot per input channel; every slot is emptied together on fire.
    for (genvar g = 0; g < K; g++) begin : g_in_slot
        token_slot #(.W(N)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .r    (r_i[g]),
            .d    (d_i[g*N +: N]),
            .clr  (fire),
            .a    (a_i[g]),
            .full (in_full[g]),
            .q    (in_q[g])
        );
    end

    token_slot #(.W(CW)) u_ctl_slot (
        .clk  (clk),
        .rst  (rst),
        .r    (ctl_r),
        .d    (ctl_d),
        .clr  (fire),
        .a    (actl_i),
        .full (ctl_full),
        .q    (ctl_q)
    );

    // A transaction completes once every slot holds a token and the output
    // register is free or being emptied on this same edge.
    assign fire     = (&in_full) && ctl_full && (!out_valid || a_o);
    assign in_range = ({1'b0, ctl_q} < K_LIM);

    // Pick the held token named by the control index.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < K; k++) begin
            if (ctl_q == CW'(k)) sel_data = in_q[k];
        end
    end

    // Output register: loads on an in-range fire, otherwise drains on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fire && in_range) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
        end else if (out_valid && a_o) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error for a consumed index that names no input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (fire && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign r_o   = out_valid;
    assign d_o   = out_data;
    assign err_o = err_q;

`ifdef SWAP_SINK_N_DROP_CNT_EN
    localparam logic [DCW+4:0] DROP_SAT = {5'b0, {DCW{1'b1}}};
    localparam logic [DCW+4:0] ADD_OK   = (DCW+5)'(K - 1);
    localparam logic [DCW+4:0] ADD_BAD  = (DCW+5)'(K);

    logic [DCW-1:0] drop_q;
    logic [DCW+4:0] drop_sum;

    assign drop_sum = {5'b0, drop_q} + (in_range ? ADD_OK : ADD_BAD);

    // Count discarded tokens per fire, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (fire) begin
            drop_q <= (drop_sum > DROP_SAT) ? {DCW{1'b1}} : drop_sum[DCW-1:0];
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_swap_sink_n.sv
// Bench for swap_sink_n: three instances (K=2 with a 4-bit drop counter,
// K=3, K=4), directed scenarios plus randomized transactions checked against
// a queue-based reference of the selection rules.
`timescale 1ns/1ps
module tb_swap_sink_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus per instance (index 0: K=2, 1: K=3, 2: K=4).
    logic [3:0]  r_i_v   [3];
    logic [31:0] d_i_v   [3];
    logic        ctl_r_v [3];
    logic [1:0]  ctl_d_v [3];
    logic [2:0]  ao_force;
    logic [2:0]  rnd_ao;
    logic        rand_ao;
    wire  [2:0]  a_o_eff = rand_ao ? rnd_ao : ao_force;

    // Observed outputs gathered into arrays.
    logic [3:0]  a_i_v   [3];
    logic        actl_v  [3];
    logic        r_o_v   [3];
    logic [7:0]  d_o_v   [3];
    logic        err_v   [3];

    logic [1:0] a_i2; logic [2:0] a_i3; logic [3:0] a_i4;
    logic actl2, actl3, actl4, r_o2, r_o3, r_o4, err2, err3, err4;
    logic [7:0] d_o2, d_o3, d_o4;
`ifdef SWAP_SINK_N_DROP_CNT_EN
    logic [3:0]  drop2;
    logic [15:0] drop3, drop4;
    logic [15:0] drop_v [3];
    assign drop_v[0] = {12'b0, drop2};
    assign drop_v[1] = drop3;
    assign drop_v[2] = drop4;
`endif

    assign a_i_v[0] = {2'b00, a_i2};
    assign a_i_v[1] = {1'b0, a_i3};
    assign a_i_v[2] = a_i4;
    assign actl_v[0] = actl2; assign actl_v[1] = actl3; assign actl_v[2] = actl4;
    assign r_o_v[0]  = r_o2;  assign r_o_v[1]  = r_o3;  assign r_o_v[2]  = r_o4;
    assign d_o_v[0]  = d_o2;  assign d_o_v[1]  = d_o3;  assign d_o_v[2]  = d_o4;
    assign err_v[0]  = err2;  assign err_v[1]  = err3;  assign err_v[2]  = err4;

    swap_sink_n #(.N(8), .K(2), .DCW(4)) u_k2 (
        .clk(clk), .rst(rst), .r_i(r_i_v[0][1:0]), .a_i(a_i2), .d_i(d_i_v[0][15:0]),
        .ctl_r(ctl_r_v[0]), .actl_i(actl2), .ctl_d(ctl_d_v[0][0:0]),
        .r_o(r_o2), .a_o(a_o_eff[0]), .d_o(d_o2), .err_o(err2)
`ifdef SWAP_SINK_N_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

    swap_sink_n #(.N(8), .K(3), .DCW(16)) u_k3 (
        .clk(clk), .rst(rst), .r_i(r_i_v[1][2:0]), .a_i(a_i3), .d_i(d_i_v[1][23:0]),
        .ctl_r(ctl_r_v[1]), .actl_i(actl3), .ctl_d(ctl_d_v[1]),
        .r_o(r_o3), .a_o(a_o_eff[1]), .d_o(d_o3), .err_o(err3)
`ifdef SWAP_SINK_N_DROP_CNT_EN
        , .drop_cnt(drop3)
`endif
    );

    swap_sink_n #(.N(8), .K(4), .DCW(16)) u_k4 (
        .clk(clk), .rst(rst), .r_i(r_i_v[2]), .a_i(a_i4), .d_i(d_i_v[2]),
        .ctl_r(ctl_r_v[2]), .actl_i(actl4), .ctl_d(ctl_d_v[2]),
        .r_o(r_o4), .a_o(a_o_eff[2]), .d_o(d_o4), .err_o(err4)
`ifdef SWAP_SINK_N_DROP_CNT_EN
        , .drop_cnt(drop4)
`endif
    );

    // Reference model state: pending outputs, sticky error, drop total.
    logic [7:0] exp_q [3][$];
    int         exp_err  [3];
    int         exp_drop [3];

    function automatic int k_of(input int w);
        return w + 2;
    endfunction

    function automatic int drop_max(input int w);
        return (w == 0) ? 15 : 65535;
    endfunction

    function automatic logic [3:0] kmask_of(input int w);
        return 4'((1 << k_of(w)) - 1);
    endfunction

    function automatic logic token_ready(input int w, input int idx);
        return (idx == k_of(w)) ? actl_v[w] : a_i_v[w][idx];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_drop(input int w);
`ifdef SWAP_SINK_N_DROP_CNT_EN
        check_output($sformatf("drop_cnt_%0d", w), 32'(drop_v[w]), 32'(exp_drop[w]));
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transaction in terms of the selection rule: forward the indexed
    // token if it names an input, otherwise flag an error; count the rest.
    task automatic model_txn(input int w, input logic [31:0] data, input logic [1:0] ctl);
        int k;
        k = k_of(w);
        if (int'(ctl) < k) begin
            exp_q[w].push_back(data[int'(ctl)*8 +: 8]);
            exp_drop[w] += k - 1;
        end else begin
            exp_err[w] = 1;
            exp_drop[w] += k;
        end
        if (exp_drop[w] > drop_max(w)) exp_drop[w] = drop_max(w);
    endtask

    // Offer one token (idx == K means control) and hold it until accepted.
    task automatic put_token(input int w, input int idx, input logic [7:0] val);
        int budget;
        budget = 60;
        @(negedge clk);
        if (idx == k_of(w)) begin
            ctl_d_v[w] = val[1:0];
            ctl_r_v[w] = 1'b1;
        end else begin
            d_i_v[w][idx*8 +: 8] = val;
            r_i_v[w][idx] = 1'b1;
        end
        while (!token_ready(w, idx) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output($sformatf("accept_timeout_%0d_%0d", w, idx), 32'(budget > 0), 32'd1);
        @(posedge clk);
        #1;
        if (idx == k_of(w)) ctl_r_v[w] = 1'b0;
        else r_i_v[w][idx] = 1'b0;
    endtask

    // Offer every token of a transaction at once; returns 1ns after accept.
    task automatic apply_stimulus(input int w, input logic [31:0] data, input logic [1:0] ctl);
        int budget;
        logic [3:0] kmask;
        kmask = kmask_of(w);
        model_txn(w, data, ctl);
        budget = 60;
        @(negedge clk);
        r_i_v[w]   = kmask;
        d_i_v[w]   = data;
        ctl_d_v[w] = ctl;
        ctl_r_v[w] = 1'b1;
        while ((((a_i_v[w] & kmask) != kmask) || !actl_v[w]) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output($sformatf("all_ready_timeout_%0d", w), 32'(budget > 0), 32'd1);
        @(posedge clk);
        #1;
        check_output($sformatf("slots_full_%0d", w), 32'({a_i_v[w] & kmask, actl_v[w]}), 32'd0);
        r_i_v[w]   = '0;
        ctl_r_v[w] = 1'b0;
    endtask

    // Random data, random index, tokens delivered one at a time in random order.
    task automatic rand_txn(input int w);
        logic [31:0] data;
        logic [1:0]  ctl;
        int order [5];
        int k, j, tmp;
        k = k_of(w);
        data = $urandom;
        ctl = (w == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        model_txn(w, data, ctl);
        for (int i = 0; i <= k; i++) order[i] = i;
        for (int i = k; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i <= k; i++) begin
            if (order[i] == k) put_token(w, k, {6'b0, ctl});
            else put_token(w, order[i], data[order[i]*8 +: 8]);
        end
    endtask

    // Random consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        rnd_ao = 3'($urandom_range(0, 7));
    end

    // Every output transfer must match the oldest expected token.
    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) begin
            if (rst && r_o_v[w] && a_o_eff[w]) begin
                check_output($sformatf("out_expected_%0d", w), 32'(exp_q[w].size() != 0), 32'd1);
                if (exp_q[w].size() != 0) begin
                    check_output($sformatf("out_data_%0d", w), 32'(d_o_v[w]), 32'(exp_q[w].pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] da, db;
        logic [1:0]  ca, cb;

        for (int w = 0; w < 3; w++) begin
            r_i_v[w] = '0; d_i_v[w] = '0; ctl_r_v[w] = 1'b0; ctl_d_v[w] = '0;
            exp_err[w] = 0; exp_drop[w] = 0;
        end
        ao_force = 3'b111;
        rand_ao  = 1'b0;
        rst      = 1'b0;
        cycles(2);

        // Reset state of every instance.
        for (int w = 0; w < 3; w++) begin
            check_output($sformatf("rst_a_i_%0d", w), 32'(a_i_v[w]), 32'(kmask_of(w)));
            check_output($sformatf("rst_actl_%0d", w), 32'(actl_v[w]), 32'd1);
            check_output($sformatf("rst_r_o_%0d", w), 32'(r_o_v[w]), 32'd0);
            check_output($sformatf("rst_d_o_%0d", w), 32'(d_o_v[w]), 32'd0);
            check_output($sformatf("rst_err_%0d", w), 32'(err_v[w]), 32'd0);
            check_drop(w);
        end
        @(negedge clk);
        rst = 1'b1;
        cycles(1);

        // K=2: all tokens together, index 1 selects 8'hBB two edges later.
        apply_stimulus(0, 32'h0000BBAA, 2'd1);
        check_output("k2_ro_before_fire", 32'(r_o_v[0]), 32'd0);
        cycles(1);
        check_output("k2_ro_after_fire", 32'(r_o_v[0]), 32'd1);
        check_output("k2_do", 32'(d_o_v[0]), 32'hBB);
        cycles(2);
        check_drop(0);

        // K=4: staggered arrival 3,0,2,1 then control; no output until last.
        model_txn(2, 32'h335C2211, 2'd2);
        put_token(2, 3, 8'h33);
        check_output("k4_stag_after3", 32'(r_o_v[2]), 32'd0);
        put_token(2, 0, 8'h11);
        check_output("k4_stag_after0", 32'(r_o_v[2]), 32'd0);
        put_token(2, 2, 8'h5C);
        check_output("k4_stag_after2", 32'(r_o_v[2]), 32'd0);
        put_token(2, 1, 8'h22);
        check_output("k4_stag_after1", 32'(r_o_v[2]), 32'd0);
        put_token(2, 4, 8'h02);
        check_output("k4_stag_last_edge", 32'(r_o_v[2]), 32'd0);
        cycles(1);
        check_output("k4_stag_ro", 32'(r_o_v[2]), 32'd1);
        check_output("k4_stag_do", 32'(d_o_v[2]), 32'h5C);
        cycles(2);
        check_drop(2);

        // K=4 backpressure: two transactions queued behind a stalled output.
        ao_force[2] = 1'b0;
        da = $urandom; ca = 2'($urandom_range(0, 3));
        db = $urandom; cb = 2'($urandom_range(0, 3));
        apply_stimulus(2, da, ca);
        apply_stimulus(2, db, cb);
        cycles(3);
        check_output("bp_a_i_stalled", 32'(a_i_v[2]), 32'd0);
        check_output("bp_actl_stalled", 32'(actl_v[2]), 32'd0);
        check_output("bp_ro_held", 32'(r_o_v[2]), 32'd1);
        check_output("bp_do_first", 32'(d_o_v[2]), 32'(da[int'(ca)*8 +: 8]));
        ao_force[2] = 1'b1;
        cycles(4);
        check_output("bp_drained", 32'(exp_q[2].size()), 32'd0);
        check_output("bp_ro_idle", 32'(r_o_v[2]), 32'd0);
        check_drop(2);

        // K=3 out-of-range index: nothing forwarded, error set, slots freed.
        apply_stimulus(1, 32'h00CCBBAA, 2'd3);
        cycles(1);
        check_output("k3_bad_no_out", 32'(r_o_v[1]), 32'd0);
        check_output("k3_bad_err", 32'(err_v[1]), 32'd1);
        check_output("k3_bad_a_i", 32'(a_i_v[1]), 32'h7);
        check_output("k3_bad_actl", 32'(actl_v[1]), 32'd1);
        check_drop(1);

        // Randomized transactions with a randomly ready consumer.
        rand_ao = 1'b1;
        repeat (20) rand_txn(0);
        repeat (12) rand_txn(1);
        repeat (12) rand_txn(2);
        rand_ao = 1'b0;
        cycles(6);
        for (int w = 0; w < 3; w++) begin
            check_output($sformatf("rand_drained_%0d", w), 32'(exp_q[w].size()), 32'd0);
            check_output($sformatf("rand_err_%0d", w), 32'(err_v[w]), 32'(exp_err[w]));
            check_drop(w);
        end

        // Asynchronous reset with three of four K=4 input slots occupied.
        put_token(2, 0, 8'hA1);
        put_token(2, 1, 8'hA2);
        put_token(2, 2, 8'hA3);
        check_output("partial_a_i", 32'(a_i_v[2]), 32'h8);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_output("async_rst_a_i", 32'(a_i_v[2]), 32'hF);
        check_output("async_rst_actl", 32'(actl_v[2]), 32'd1);
        check_output("async_rst_r_o", 32'(r_o_v[2]), 32'd0);
        check_output("async_rst_err_k3", 32'(err_v[1]), 32'd0);
        for (int w = 0; w < 3; w++) begin
            exp_q[w].delete();
            exp_err[w]  = 0;
            exp_drop[w] = 0;
        end
        check_drop(1);
        @(negedge clk);
        rst = 1'b1;
        cycles(1);

        // Fresh transaction after reset behaves normally.
        apply_stimulus(2, 32'hDDCCBBAA, 2'd3);
        cycles(1);
        check_output("post_rst_ro", 32'(r_o_v[2]), 32'd1);
        check_output("post_rst_do", 32'(d_o_v[2]), 32'hDD);
        cycles(3);
        check_output("post_rst_drained", 32'(exp_q[2].size()), 32'd0);
        check_drop(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/swap_sink_n.md
Name: swap_sink_n

Overview:
- Clocked, parametrised successor to the two-way swap-with-sink: K input channels and one control channel feed a single output channel.
- Each transaction consumes one token from every input plus one control token. The input named by the control index goes to the output; the other K-1 tokens are absorbed by an internal sink.
- Sits in condflow between data producers and a single consumer. Used for N-way conditional selection where every unselected producer must still be drained.

Parameters:
- N, 1, data width per channel in bits.
- K, 2, number of input channels (2..16).
- DCW, 16, width of the drop counter.
- localparam CW = (K>1) ? $clog2(K) : 1, width of the control index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets). Polarity is fixed; there is no Rpol parameter.
- r_i  input  K  per-input request (valid).
- a_i  output  K  per-input acknowledge (ready).
- d_i  input  K*N  input data; channel k occupies bits [k*N +: N].
- ctl_r  input  1  control request.
- actl_i  output  1  control acknowledge.
- ctl_d  input  CW  control index selecting the forwarded input.
- r_o  output  1  output request.
- a_o  input  1  output acknowledge.
- d_o  output  N  output data.
- err_o  output  1  sticky flag: an out-of-range control index was consumed.
- drop_cnt  output  DCW  count of discarded tokens (present only with the optional feature).

Behaviour:
- Handshake, all channels: a transfer occurs on a rising edge where r and a are both 1. A producer holds r and d stable until that edge.
- Each input and the control channel has a one-entry slot with a full flag; a_i[k] = !full_i[k] and actl_i = !full_c.
- A slot fills independently on its own transfer. Inputs may arrive in any order over any number of cycles.
- The block is two-state, with "fire" as the only transition:
  - COLLECT (implicit): waiting for all slots to fill.
  - FIRE condition: fire = all K input slots full AND control slot full AND (!out_valid OR a_o).
- On a fire edge:
  - All K+1 full flags clear.
  - If ctl index < K: out_data <= slot[ctl index], out_valid <= 1.
  - If ctl index >= K (only possible when K is not a power of 2): nothing is forwarded, all K tokens are dropped, and err_o is set.
- Output register: r_o = out_valid, d_o = out_data. out_valid clears on a_o&&r_o unless a fire on the same edge reloads it.
- Latency: last missing token accepted at edge T -> fire at edge T+1 -> r_o=1 after T+1.
- Throughput: one transaction per 2 cycles, because slots are not ready during the fire cycle.
- Backpressure: while out_valid=1 and a_o=0, fire is blocked and all slots stay full and stalled.
- Drop accounting: each fire adds K-1 to the drop count (K on an out-of-range index).
- Reset values: all full flags 0, a_i = all 1, actl_i = 1, r_o = 0, d_o = 0, err_o = 0, drop_cnt = 0.
- Reset mid-operation: all held tokens are lost. There is no partial-transaction recovery; producers must also be reset.
- err_o clears only on reset.
- d_o changes only when out_valid loads.

Optional Feature:
- Macro SWAP_SINK_N_DROP_CNT_EN.
- Defined: drop_cnt port exists; a DCW-bit counter saturates at all-ones and does not wrap.
- Undefined: the port and counter are removed; all other behaviour is identical.

Decomposition:
- Package condflow_pkg:
  - clog2-safe width function, used for CW.
  - typedef for the slot state (full flag + data).
  - localparam for max K = 16.
- Sub-module token_slot #(W): a one-entry clocked slot with inputs r, d, clr and outputs a, full, q; async active-low reset.
- The top instantiates token_slot K times for the inputs and once (W=CW) for control.

Test Plan:
- K=2, N=8: d_i = {8'hBB, 8'hAA}, ctl_d=1, all r asserted together -> r_o rises 2 cycles later with d_o=8'hBB; drop_cnt=1.
- K=4: inputs arrive in staggered order 3,0,2,1, then ctl_d=2 on input 2 = 8'h5C -> no fire until the last token; d_o=8'h5C one cycle after the last accept; drop_cnt=3.
- Hold a_o=0 across two full transaction sets -> the second set stalls with a_i=0; after a_o pulses, exactly two outputs arrive in order with no loss.
- K=3, ctl_d=3 -> no r_o, err_o=1, all a_i return to 1, drop_cnt increases by 3.
- DCW=4, K=2: 20 transactions -> drop_cnt saturates at 4'hF.
- Assert rst=0 with 3 of 4 slots full -> a_i = all 1, r_o=0, err_o=0 immediately (asynchronous); a fresh transaction afterwards behaves normally.
